coord_to_ram_banked: RTL

- Maps raster display coordinates (x, y) to a one-hot RAM bank select and in-bank read address for the waterfall spectrogram store.
- Parametrised successor to the fixed two-bank mapper, with:
  - generalised bank count;
  - configurable pixel scaling and prefetch offset;
  - a valid pipeline;
  - frame-synchronous latching of the ring-buffer head;
  - out-of-area blanking.
- Sits between the video timing generator and the shared spectrum RAM read port.

---
 rtl/coord_to_ram_banked_if.sv | 24 ++
 rtl/coord_to_ram_banked.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/coord_to_ram_banked_if.sv
// rtl/coord_to_ram_banked_if.sv - coordinate stream in / banked RAM read request out
interface coord_to_ram_banked_if #(
    parameter int NO_BANKS       = 2,
    parameter int COORDW         = 16,
    parameter int RAM_ADDR_WIDTH = 12
);
    logic                      in_valid;
    logic [COORDW-1:0]         x;
    logic [COORDW-1:0]         y;
    logic                      out_valid;
    logic [NO_BANKS-1:0]       rd_bank_select;
    logic [RAM_ADDR_WIDTH-1:0] rd_address;
    logic                      out_blank;

    modport master (
        output in_valid, x, y,
        input  out_valid, rd_bank_select, rd_address, out_blank
    );

    modport slave (
        input  in_valid, x, y,
        output out_valid, rd_bank_select, rd_address, out_blank
    );
endinterface

// File: rtl/coord_to_ram_banked.sv
// rtl/coord_to_ram_banked.sv - raster (x,y) to one-hot bank + address, 3-stage; WATERFALL_FLIP_EN draws newest FFT on top
module coord_to_ram_banked #(
    parameter int NO_BANKS       = 2,
    parameter int COORDW         = 16,
    parameter int RAM_ADDR_WIDTH = 12,
    parameter int NO_FFTS        = 50,
    parameter int FFT_SIZE       = 256,
    parameter int X_SHIFT        = 2,
    parameter int Y_SHIFT        = 4,
    parameter int X_OFFSET       = 1,
    localparam int BIN_W         = $clog2(FFT_SIZE / 2),
    localparam int FPB_W         = RAM_ADDR_WIDTH - BIN_W,
    localparam int IDXW          = $clog2(NO_FFTS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    coord_to_ram_banked_if.slave          bus,
    input  logic                          frame_start,
    input  logic [IDXW-1:0]               oldest_fft_idx,
    output logic                          idx_err
);
    localparam int EXTW = IDXW + FPB_W;

    generate
        if (NO_FFTS > NO_BANKS * (2 ** FPB_W)) begin : g_depth_check
            $error("coord_to_ram_banked: NO_FFTS exceeds total bank capacity");
        end
    endgenerate

    // Ring head, only updated at frame boundaries so a frame never tears.
    logic [IDXW-1:0] head_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            idx_err <= 1'b0;
        end else if (frame_start) begin
            if (32'(oldest_fft_idx) >= NO_FFTS) begin
                head_q  <= '0;
                idx_err <= 1'b1;
            end else begin
                head_q  <= oldest_fft_idx;
            end
        end
    end

    logic [COORDW-1:0] xs;
    logic [COORDW-1:0] bin_full;
    logic [COORDW-1:0] row_full;
    logic              blank_c;
    logic [IDXW-1:0]   row_c;

    always_comb begin
        xs       = bus.x + COORDW'(X_OFFSET);
        bin_full = xs >> X_SHIFT;
        row_full = bus.y >> Y_SHIFT;
        blank_c  = (bin_full >= COORDW'(FFT_SIZE / 2)) || (row_full >= COORDW'(NO_FFTS));
`ifdef WATERFALL_FLIP_EN
        if (row_full < COORDW'(NO_FFTS)) begin
            row_c = IDXW'(NO_FFTS - 1) - row_full[IDXW-1:0];
        end else begin
            row_c = row_full[IDXW-1:0];
        end
`else
        row_c = row_full[IDXW-1:0];
`endif
    end

    // Stage 1 also snapshots the head so a sample coincident with frame_start
    // keeps the previous frame's head.
    logic             v1;
    logic [BIN_W-1:0] bin1;
    logic [IDXW-1:0]  row1;
    logic [IDXW-1:0]  head1;
    logic             blank1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1     <= 1'b0;
            bin1   <= '0;
            row1   <= '0;
            head1  <= '0;
            blank1 <= 1'b0;
        end else begin
            v1 <= bus.in_valid;
            if (bus.in_valid) begin
                bin1   <= bin_full[BIN_W-1:0];
                row1   <= row_c;
                head1  <= head_q;
                blank1 <= blank_c;
            end
        end
    end

    logic [IDXW:0]   sum;
    logic [IDXW:0]   sum_wrapped;
    logic [IDXW-1:0] idx_c;

    always_comb begin
        sum         = {1'b0, head1} + {1'b0, row1};
        sum_wrapped = sum - (IDXW + 1)'(NO_FFTS);
        if (sum >= (IDXW + 1)'(NO_FFTS)) begin
            idx_c = sum_wrapped[IDXW-1:0];
        end else begin
            idx_c = sum[IDXW-1:0];
        end
    end

    logic             v2;
    logic [IDXW-1:0]  idx2;
    logic [BIN_W-1:0] bin2;
    logic             blank2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2     <= 1'b0;
            idx2   <= '0;
            bin2   <= '0;
            blank2 <= 1'b0;
        end else begin
            v2 <= v1;
            if (v1) begin
                idx2   <= idx_c;
                bin2   <= bin1;
                blank2 <= blank1;
            end
        end
    end

    // Upper index bits pick the bank, lower FPB_W bits pick the FFT slot within it.
    logic [EXTW-1:0]           idx_ext;
    logic [EXTW-1:0]           bank;
    logic [NO_BANKS-1:0]       sel_c;
    logic [RAM_ADDR_WIDTH-1:0] addr_c;

    always_comb begin
        idx_ext = EXTW'(idx2);
        bank    = idx_ext >> FPB_W;
        sel_c   = NO_BANKS'(1) << bank;
        addr_c  = {idx_ext[FPB_W-1:0], bin2};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.out_valid      <= 1'b0;
            bus.rd_bank_select <= '0;
            bus.rd_address     <= '0;
            bus.out_blank      <= 1'b0;
        end else begin
            bus.out_valid <= v2;
            if (v2) begin
                if (blank2) begin
                    bus.rd_bank_select <= '0;
                    bus.rd_address     <= '0;
                    bus.out_blank      <= 1'b1;
                end else begin
                    bus.rd_bank_select <= sel_c;
                    bus.rd_address     <= addr_c;
                    bus.out_blank      <= 1'b0;
                end
            end
        end
    end
endmodule
